ps2_keymap_decoder: RTL and testbench
=====================================

PS2_KEYMAP_DECODER -- requirements
Module: ps2_keymap_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, output character buffer depth (power of 2, >=2).
REQ-002 SHALL have parameter CNT_W, default $clog2(FIFO_DEPTH+1), width of fifo_count.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 code_in  in  8  PS/2 scancode byte (set 2).
REQ-006 code_valid  in  1  one-cycle strobe, code_in valid.
REQ-007 ascii_out  out  8  ASCII character at FIFO head.
REQ-008 ascii_valid  out  1  FIFO non-empty.
REQ-009 ascii_ready  in  1  consumer accepts ascii_out.
REQ-010 shift_active  out  1  left or right shift held.
REQ-011 caps_active  out  1  caps-lock toggle state.
REQ-012 overflow  out  1  sticky: character dropped on full FIFO.
REQ-013 fifo_count  out  CNT_W  characters buffered.

Function
REQ-014 Prefix FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0); only bytes with code_valid=1 advance it.
REQ-015 IDLE: F0->BRK; E0->EXT; 00/FF->IDLE, no output; other byte = make code, handled per REQ-017..020, stay IDLE.
REQ-016 BRK: any byte = break code, no output, ->IDLE; EXT: F0->EXT_BRK, else ->IDLE no output; EXT_BRK: any byte ->IDLE no output.
REQ-017 Make/break of 12 (left shift) and 59 (right shift) set/clear separate held flags; shift_active = OR of flags; no output.
REQ-018 Letters (1C=A ... 1A=Z, full set-2 letter map): uppercase 41-5A when shift_active XOR caps_active, else lowercase 61-7A.
REQ-019 Digits 70,69,72,7A,6B,73,74,6C,75,7D -> 30-39 unshifted; shifted -> ) ! @ # $ % ^ & * ( (29,21,40,23,24,25,5E,26,2A,28); caps-lock has no effect.
REQ-020 29->20 (space), 5A->0D (enter), 66->08 (backspace), shift-independent; all other make codes produce no output.
REQ-021 Producing make code pushes its character at the same edge code_valid is sampled; ascii_valid rises the following cycle (latency 1, no bypass).
REQ-022 FIFO show-ahead: ascii_out = head whenever ascii_valid=1; pop on ascii_valid & ascii_ready; ascii_out undefined-but-stable (hold last) when empty.
REQ-023 Pointers wrap modulo FIFO_DEPTH; fifo_count = pushes - pops, range 0..FIFO_DEPTH.
REQ-024 Full and push without pop: character dropped, overflow set, contents unchanged.
REQ-025 Full with simultaneous push and pop: both performed, count stays FIFO_DEPTH, overflow unchanged.
REQ-026 Empty with push: ascii_ready ignored that cycle; no pop of an empty FIFO ever occurs.
REQ-027 Typematic repeat of a held key make code pushes one character per repeat.

Reset
REQ-028 rst=1 at a rising edge: FSM->IDLE, shift flags/caps/caps-held clear, FIFO emptied, overflow=0, fifo_count=0, ascii_valid=0, ascii_out=00.
REQ-029 Reset mid-prefix (e.g. after F0) discards prefix; next byte decoded from IDLE.
REQ-030 Inputs ignored during reset cycle; no push or pop occurs.

Configuration
REQ-031 Macro PS2_CAPSLOCK_EN defined: make code 58 toggles caps_active only when caps-held flag clear, then sets flag; break 58 clears flag (repeats do not toggle).
REQ-032 PS2_CAPSLOCK_EN undefined: caps_active tied 0, code 58 produces no output and no state, letters case by shift only.

Structure
REQ-033 Package ps2_pkg SHALL hold prefix constants (E0, F0), shift/caps codes, FSM state enum, and the scancode->character lookup function (base and shifted tables).
REQ-034 FIFO SHALL be sub-module ps2_char_fifo (parametrised by depth and width 8); decoder FSM and modifier tracking in the top module.

Verification
REQ-035 Reset, send 1C -> one cycle later ascii_valid=1, ascii_out=61; ascii_ready=1 -> empty, fifo_count=0.
REQ-036 Send 12,1C,F0,1C,F0,12,1C -> outputs 41 then 61 in order; shift_active 1 between 12 and F0 12.
REQ-037 With PS2_CAPSLOCK_EN: 58,58,58,F0,58,32 -> caps_active=1 (single toggle), output 42; then 12,32 -> 62.
REQ-038 ascii_ready=0, send 9 x 29 with FIFO_DEPTH=8 -> fifo_count=8, overflow=1, eight 20 drained; then full+push+pop same cycle keeps count 8.
REQ-039 E0,75 / E0,F0,75 / F0,69 / FF -> no output, FSM IDLE after each; following 69 -> 31.
REQ-040 Send F0, assert rst, then 1C -> output 61 (prefix discarded), overflow=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, prefix FSM states and the set-2 scancode to ASCII lookup
// used by the PS/2 keymap decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
  localparam logic [7:0] PS2_NULL    = 8'h00;
  localparam logic [7:0] PS2_ERR     = 8'hFF;
  localparam logic [7:0] PS2_LSHIFT  = 8'h12;
  localparam logic [7:0] PS2_RSHIFT  = 8'h59;
  localparam logic [7:0] PS2_CAPS    = 8'h58;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       valid;
    logic       letter;
    logic [7:0] base;
    logic [7:0] shifted;
  } ps2_char_t;

  function automatic ps2_char_t mk_letter(input logic [7:0] upper);
    ps2_char_t r;
    r.valid   = 1'b1;
    r.letter  = 1'b1;
    r.base    = upper | 8'h20;
    r.shifted = upper;
    return r;
  endfunction

  function automatic ps2_char_t mk_sym(input logic [7:0] base, input logic [7:0] shifted);
    ps2_char_t r;
    r.valid   = 1'b1;
    r.letter  = 1'b0;
    r.base    = base;
    r.shifted = shifted;
    return r;
  endfunction

  // Letters carry their uppercase form; digits carry base and shifted symbol.
  function automatic ps2_char_t ps2_lookup(input logic [7:0] code);
    ps2_char_t r;
    r = '0;
    case (code)
      8'h1C: r = mk_letter(8'h41);
      8'h32: r = mk_letter(8'h42);
      8'h21: r = mk_letter(8'h43);
      8'h23: r = mk_letter(8'h44);
      8'h24: r = mk_letter(8'h45);
      8'h2B: r = mk_letter(8'h46);
      8'h34: r = mk_letter(8'h47);
      8'h33: r = mk_letter(8'h48);
      8'h43: r = mk_letter(8'h49);
      8'h3B: r = mk_letter(8'h4A);
      8'h42: r = mk_letter(8'h4B);
      8'h4B: r = mk_letter(8'h4C);
      8'h3A: r = mk_letter(8'h4D);
      8'h31: r = mk_letter(8'h4E);
      8'h44: r = mk_letter(8'h4F);
      8'h4D: r = mk_letter(8'h50);
      8'h15: r = mk_letter(8'h51);
      8'h2D: r = mk_letter(8'h52);
      8'h1B: r = mk_letter(8'h53);
      8'h2C: r = mk_letter(8'h54);
      8'h3C: r = mk_letter(8'h55);
      8'h2A: r = mk_letter(8'h56);
      8'h1D: r = mk_letter(8'h57);
      8'h22: r = mk_letter(8'h58);
      8'h35: r = mk_letter(8'h59);
      8'h1A: r = mk_letter(8'h5A);
      8'h70: r = mk_sym(8'h30, 8'h29);
      8'h69: r = mk_sym(8'h31, 8'h21);
      8'h72: r = mk_sym(8'h32, 8'h40);
      8'h7A: r = mk_sym(8'h33, 8'h23);
      8'h6B: r = mk_sym(8'h34, 8'h24);
      8'h73: r = mk_sym(8'h35, 8'h25);
      8'h74: r = mk_sym(8'h36, 8'h5E);
      8'h6C: r = mk_sym(8'h37, 8'h26);
      8'h75: r = mk_sym(8'h38, 8'h2A);
      8'h7D: r = mk_sym(8'h39, 8'h28);
      8'h29: r = mk_sym(8'h20, 8'h20);
      8'h5A: r = mk_sym(8'h0D, 8'h0D);
      8'h66: r = mk_sym(8'h08, 8'h08);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_char_fifo.sv
// Show-ahead character FIFO with sticky overflow; pops only when non-empty and
// holds the last shown character on ascii_out once drained.
module ps2_char_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_req,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             ovf_q, ovf_d;
  logic             full, do_pop, do_push;

  assign rd_valid = (count_q != '0);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : last_q;
  assign count    = count_q;
  assign overflow = ovf_q;

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    do_pop   = pop_req && rd_valid;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push  = push && (!full || do_pop);
    ovf_d    = ovf_q | (push & full & ~do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = rd_valid ? mem_q[rd_ptr_q] : last_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: rtl/ps2_keymap_decoder.sv
// PS/2 set-2 scancode to ASCII decoder: prefix FSM, shift/caps tracking and
// an output character FIFO. Caps-lock support is built when PS2_CAPSLOCK_EN is defined.
//
// state      | meaning
// ST_IDLE    | no prefix pending; next byte is a make code or a prefix
// ST_BRK     | F0 seen; next byte is a break code
// ST_EXT     | E0 seen; extended key, never produces output
// ST_EXT_BRK | E0 F0 seen; next byte ends the extended break
module ps2_keymap_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       code_in,
  input  logic             code_valid,
  output logic [7:0]       ascii_out,
  output logic             ascii_valid,
  input  logic             ascii_ready,
  output logic             shift_active,
  output logic             caps_active,
  output logic             overflow,
  output logic [CNT_W-1:0] fifo_count
);

  ps2_state_e state_q, state_d;
  logic       lshift_q, lshift_d;
  logic       rshift_q, rshift_d;
  logic       push;
  logic [7:0] push_char;
  logic       use_shift;
  ps2_char_t  lut;
  logic       caps_now;

`ifdef PS2_CAPSLOCK_EN
  logic caps_q, caps_d;
  logic caps_held_q, caps_held_d;
  assign caps_now = caps_q;
`else
  assign caps_now = 1'b0;
`endif

  assign shift_active = lshift_q | rshift_q;
  assign caps_active  = caps_now;

  always_comb begin
    state_d   = state_q;
    lshift_d  = lshift_q;
    rshift_d  = rshift_q;
`ifdef PS2_CAPSLOCK_EN
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
`endif
    push      = 1'b0;
    push_char = 8'h00;
    lut       = ps2_lookup(code_in);
    use_shift = lut.letter ? (shift_active ^ caps_now) : shift_active;
    if (code_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (code_in == PS2_PFX_BRK) begin
            state_d = ST_BRK;
          end else if (code_in == PS2_PFX_EXT) begin
            state_d = ST_EXT;
          end else if (code_in == PS2_NULL || code_in == PS2_ERR) begin
            state_d = ST_IDLE;
          end else if (code_in == PS2_LSHIFT) begin
            lshift_d = 1'b1;
          end else if (code_in == PS2_RSHIFT) begin
            rshift_d = 1'b1;
`ifdef PS2_CAPSLOCK_EN
          end else if (code_in == PS2_CAPS) begin
            // Typematic repeats arrive while held and must not re-toggle.
            if (!caps_held_q) caps_d = ~caps_q;
            caps_held_d = 1'b1;
`endif
          end else if (lut.valid) begin
            push      = 1'b1;
            push_char = use_shift ? lut.shifted : lut.base;
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          if (code_in == PS2_LSHIFT) lshift_d = 1'b0;
          if (code_in == PS2_RSHIFT) rshift_d = 1'b0;
`ifdef PS2_CAPSLOCK_EN
          if (code_in == PS2_CAPS) caps_held_d = 1'b0;
`endif
        end
        ST_EXT:     state_d = (code_in == PS2_PFX_BRK) ? ST_EXT_BRK : ST_IDLE;
        ST_EXT_BRK: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
`ifdef PS2_CAPSLOCK_EN
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      lshift_q <= lshift_d;
      rshift_q <= rshift_d;
`ifdef PS2_CAPSLOCK_EN
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
`endif
    end
  end

  ps2_char_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_char),
    .pop_req  (ascii_ready),
    .rd_data  (ascii_out),
    .rd_valid (ascii_valid),
    .count    (fifo_count),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_ps2_keymap_decoder.sv
// Self-checking bench: directed scenarios plus randomized scancode traffic,
// compared every cycle against a queue-based behavioural keyboard model.
module tb_ps2_keymap_decoder;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       code_in;
  logic             code_valid;
  logic [7:0]       ascii_out;
  logic             ascii_valid;
  logic             ascii_ready;
  logic             shift_active;
  logic             caps_active;
  logic             overflow;
  logic [CNT_W-1:0] fifo_count;

  always #5 clk = ~clk;

  ps2_keymap_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .code_in     (code_in),
    .code_valid  (code_valid),
    .ascii_out   (ascii_out),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .shift_active(shift_active),
    .caps_active (caps_active),
    .overflow    (overflow),
    .fifo_count  (fifo_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural keyboard model: key tables, prefix flags, character queue.
  logic [7:0] letter_codes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                    8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                    8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] digit_codes [10] = '{8'h70,8'h69,8'h72,8'h7A,8'h6B,8'h73,8'h74,8'h6C,8'h75,8'h7D};
  string      digit_shift = ")!@#$%^&*(";

  logic [7:0] m_q [$];
  bit         m_after_e0, m_after_f0;
  bit         m_lsh, m_rsh, m_caps, m_caps_held, m_ovf;
  logic [7:0] m_last;

  task automatic model_reset();
    m_q.delete();
    m_after_e0 = 0; m_after_f0 = 0;
    m_lsh = 0; m_rsh = 0; m_caps = 0; m_caps_held = 0; m_ovf = 0;
    m_last = 8'h00;
  endtask

  task automatic model_make(input logic [7:0] c, output bit have, output logic [7:0] ch);
    bit sh;
    have = 0; ch = 8'h00;
    sh = m_lsh | m_rsh;
    if (c == 8'h12) m_lsh = 1;
    else if (c == 8'h59) m_rsh = 1;
`ifdef PS2_CAPSLOCK_EN
    else if (c == 8'h58) begin
      if (!m_caps_held) m_caps = !m_caps;
      m_caps_held = 1;
    end
`endif
    else begin
      for (int i = 0; i < 26; i++)
        if (c == letter_codes[i]) begin
          have = 1;
          ch = (sh ^ m_caps) ? 8'(8'h41 + i) : 8'(8'h61 + i);
        end
      for (int i = 0; i < 10; i++)
        if (c == digit_codes[i]) begin
          have = 1;
          ch = sh ? digit_shift[i] : 8'(8'h30 + i);
        end
      if (c == 8'h29) begin have = 1; ch = 8'h20; end
      if (c == 8'h5A) begin have = 1; ch = 8'h0D; end
      if (c == 8'h66) begin have = 1; ch = 8'h08; end
    end
  endtask

  task automatic model_edge(input logic r, input logic cv, input logic [7:0] c, input logic rdy);
    bit         pop, have;
    logic [7:0] ch;
    if (r) begin
      model_reset();
      return;
    end
    pop  = (m_q.size() != 0) && rdy;
    have = 0; ch = 8'h00;
    if (cv) begin
      if (m_after_e0) begin
        if (m_after_f0) begin m_after_e0 = 0; m_after_f0 = 0; end
        else if (c == 8'hF0) m_after_f0 = 1;
        else m_after_e0 = 0;
      end else if (m_after_f0) begin
        if (c == 8'h12) m_lsh = 0;
        if (c == 8'h59) m_rsh = 0;
        if (c == 8'h58) m_caps_held = 0;
        m_after_f0 = 0;
      end else if (c == 8'hF0) m_after_f0 = 1;
      else if (c == 8'hE0) m_after_e0 = 1;
      else if (c != 8'h00 && c != 8'hFF) model_make(c, have, ch);
    end
    if (pop) void'(m_q.pop_front());
    if (have) begin
      if (m_q.size() < DEPTH) m_q.push_back(ch);
      else m_ovf = 1;
    end
    if (m_q.size() != 0) m_last = m_q[0];
  endtask

  task automatic compare_all();
    check_eq("ascii_valid", ascii_valid, m_q.size() != 0);
    check_eq("fifo_count", fifo_count, m_q.size());
    check_eq("ascii_out", ascii_out, m_last);
    check_eq("overflow", overflow, m_ovf);
    check_eq("shift_active", shift_active, m_lsh | m_rsh);
    check_eq("caps_active", caps_active, m_caps);
  endtask

  task automatic step(input logic r, input logic cv, input logic [7:0] c, input logic rdy);
    rst = r; code_valid = cv; code_in = c; ascii_ready = rdy;
    @(posedge clk);
    model_edge(r, cv, c, rdy);
    #1;
    compare_all();
  endtask

  task automatic send(input logic [7:0] c);
    step(1'b0, 1'b1, c, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 8'h00, rdy);
  endtask

  function automatic logic [7:0] rand_code();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2, 3: rand_code = letter_codes[$urandom_range(0, 25)];
      4:          rand_code = digit_codes[$urandom_range(0, 9)];
      5: begin
        k = $urandom_range(0, 2);
        rand_code = (k == 0) ? 8'h29 : (k == 1) ? 8'h5A : 8'h66;
      end
      6: begin
        k = $urandom_range(0, 2);
        rand_code = (k == 0) ? 8'h12 : (k == 1) ? 8'h59 : 8'h58;
      end
      7:       rand_code = $urandom_range(0, 1) ? 8'hF0 : 8'hE0;
      8:       rand_code = $urandom_range(0, 1) ? 8'h00 : 8'hFF;
      default: rand_code = 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    model_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h1C, 1'b1);
    check_eq("reset_out", ascii_out, 8'h00);
    check_eq("reset_count", fifo_count, 0);

    // Single key, then consume it.
    send(8'h1C);
    check_eq("single_valid", ascii_valid, 1'b1);
    check_eq("single_out", ascii_out, 8'h61);
    idle(1'b1);
    check_eq("single_drained", fifo_count, 0);

    // Shifted and unshifted A with shift make/break.
    send(8'h12);
    check_eq("shift_held", shift_active, 1'b1);
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    check_eq("shift_released", shift_active, 1'b0);
    send(8'h1C);
    check_eq("shift_head", ascii_out, 8'h41);
    idle(1'b1);
    check_eq("shift_second", ascii_out, 8'h61);
    idle(1'b1);

`ifdef PS2_CAPSLOCK_EN
    send(8'h58); send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
    check_eq("caps_single_toggle", caps_active, 1'b1);
    send(8'h32);
    check_eq("caps_upper", ascii_out, 8'h42);
    idle(1'b1);
    send(8'h12); send(8'h32);
    check_eq("caps_shift_lower", ascii_out, 8'h62);
    idle(1'b1);
    send(8'hF0); send(8'h12);
`endif

    // Prefixed sequences produce nothing and leave the FSM idle.
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hF0); send(8'h69);
    send(8'hFF);
    check_eq("prefix_no_output", fifo_count, 0);
    send(8'h69);
    check_eq("prefix_then_digit", ascii_out, 8'h31);
    idle(1'b1);

    // Overflow: nine spaces into an eight-deep FIFO.
    for (int i = 0; i < 9; i++) send(8'h29);
    check_eq("ovf_count", fifo_count, DEPTH);
    check_eq("ovf_flag", overflow, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("ovf_drain_char", ascii_out, 8'h20);
      idle(1'b1);
    end
    check_eq("ovf_drained", ascii_valid, 1'b0);
    for (int i = 0; i < DEPTH; i++) send(8'h29);
    step(1'b0, 1'b1, 8'h29, 1'b1);
    check_eq("full_push_pop_count", fifo_count, DEPTH);

    // Reset in the middle of a break prefix.
    send(8'hF0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    send(8'h1C);
    check_eq("reset_prefix_out", ascii_out, 8'h61);
    check_eq("reset_prefix_ovf", overflow, 1'b0);
    idle(1'b1);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 4000; n++) begin
      logic r, cv, rdy;
      r   = ($urandom_range(0, 299) == 0);
      cv  = ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 3) != 0);
      if (n % 800 < 100) rdy = 1'b0;
      step(r, cv, rand_code(), rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
